// File: rtl/pass_pkg.sv
// Shared definitions for the keypad password path (entry block and display decoder).
package pass_pkg;

  localparam int unsigned DigitW    = 4;
  localparam int unsigned NumDigits = 3;
  localparam int unsigned PassW     = DigitW * NumDigits;

  localparam logic [DigitW-1:0] KEY_CLEAR = 4'hA;
  localparam logic [DigitW-1:0] KEY_ENTER = 4'hB;
  localparam logic [DigitW-1:0] KEY_PROG  = 4'hC;

  typedef enum logic [1:0] {
    StEntry,
    StUnlocked,
    StProgram,
    StLockout
  } pass_state_e;

  function automatic logic is_digit(logic [DigitW-1:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/pass_digit_buf.sv
// Three-digit BCD shift buffer with a count that saturates at full.
module pass_digit_buf
  import pass_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              push,
  input  logic [DigitW-1:0] digit,
  input  logic              clear,
  output logic [PassW-1:0]  buffer,
  output logic [1:0]        count
);

  logic [PassW-1:0] buf_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else if (push && (cnt_q < 2'(NumDigits))) begin
      // Newest digit enters at the LSD; the first digit typed ends up as the MSD.
      buf_q <= {buf_q[PassW-DigitW-1:0], digit};
      cnt_q <= cnt_q + 2'd1;
    end
  end

  assign buffer = buf_q;
  assign count  = cnt_q;

endmodule

// File: rtl/pass_entry.sv
// Keypad password entry: digit capture, compare against stored code, fail lockout, reprogram.
module pass_entry
  import pass_pkg::*;
#(
  parameter logic [11:0] DEFAULT_PASS = 12'h666,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned LOCK_CYCLES  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_key_valid,
  input  logic [DigitW-1:0] i_key,
  output logic [PassW-1:0]  o_password,
  output logic [1:0]        o_digit_cnt,
  output logic              o_unlock,
  output logic              o_error,
  output logic              o_locked
);

  localparam int unsigned TimerW = $clog2(LOCK_CYCLES + 1);

  pass_state_e       state_q;
  logic [PassW-1:0]  stored_q;
  logic [2:0]        fail_q;
  logic [TimerW-1:0] timer_q;
  logic              error_q;

  logic             key_acc;
  logic             buf_push;
  logic             buf_clear;
  logic [PassW-1:0] buf_val;
  logic [1:0]       buf_cnt;
  logic             buf_full;

  assign key_acc  = i_key_valid & i_en;
  assign buf_full = (buf_cnt == 2'(NumDigits));

  always_comb begin
    buf_push  = 1'b0;
    buf_clear = 1'b0;
    if (key_acc) begin
      unique case (state_q)
        StEntry, StProgram: begin
          if (is_digit(i_key)) begin
            buf_push = 1'b1;
          end else if (i_key == KEY_CLEAR) begin
            buf_clear = 1'b1;
          end else if (i_key == KEY_ENTER) begin
            // A short PROGRAM entry keeps its digits so the user can finish typing.
            buf_clear = (state_q == StEntry) || buf_full;
          end
        end
        StUnlocked: buf_clear = (i_key == KEY_PROG);
        default: ;
      endcase
    end
  end

  pass_digit_buf u_digit_buf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (buf_push),
    .digit   (i_key),
    .clear   (buf_clear),
    .buffer  (buf_val),
    .count   (buf_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StEntry;
      stored_q <= DEFAULT_PASS;
      fail_q   <= '0;
      timer_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        StEntry: begin
          if (key_acc && (i_key == KEY_ENTER)) begin
            if (buf_full && (buf_val == stored_q)) begin
              state_q <= StUnlocked;
              fail_q  <= '0;
            end else if (!buf_full) begin
              error_q <= 1'b1;
            end else begin
              error_q <= 1'b1;
              if ((fail_q + 3'd1) == 3'(MAX_TRIES)) begin
                state_q <= StLockout;
                timer_q <= TimerW'(LOCK_CYCLES);
                fail_q  <= '0;
              end else begin
                fail_q <= fail_q + 3'd1;
              end
            end
          end
        end
        StUnlocked: begin
          if (key_acc && (i_key == KEY_PROG)) begin
            state_q <= StProgram;
          end else if (key_acc && (i_key == KEY_CLEAR)) begin
            state_q <= StEntry;
          end
        end
        StProgram: begin
          if (key_acc && (i_key == KEY_ENTER)) begin
            if (buf_full) begin
              stored_q <= buf_val;
              state_q  <= StUnlocked;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StLockout: begin
          // Runs independently of i_en; leaves on the edge the timer hits zero.
          timer_q <= timer_q - TimerW'(1);
          if (timer_q <= TimerW'(1)) begin
            state_q <= StEntry;
          end
        end
        default: state_q <= StEntry;
      endcase
    end
  end

  assign o_password  = buf_val;
  assign o_digit_cnt = buf_cnt;
  assign o_unlock    = (state_q == StUnlocked);
  assign o_locked    = (state_q == StLockout);
  assign o_error     = error_q;

endmodule

// File: tb/tb_pass_entry.sv
// Directed bench for pass_entry: unlock, reject, lockout, reprogram, enable gating, async reset.
module tb_pass_entry;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_en;
  logic        i_key_valid;
  logic [3:0]  i_key;
  logic [11:0] o_password;
  logic [1:0]  o_digit_cnt;
  logic        o_unlock;
  logic        o_error;
  logic        o_locked;

  int total;
  int bad;
  int err_seen;
  int lock_seen;

  pass_entry #(
    .DEFAULT_PASS (12'h666),
    .MAX_TRIES    (3),
    .LOCK_CYCLES  (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_key_valid (i_key_valid),
    .i_key       (i_key),
    .o_password  (o_password),
    .o_digit_cnt (o_digit_cnt),
    .o_unlock    (o_unlock),
    .o_error     (o_error),
    .o_locked    (o_locked)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial err_seen = 0;
  initial lock_seen = 0;
  always @(negedge i_clk) begin
    if (o_error) err_seen++;
    if (o_locked) lock_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns on the negedge after the accepting posedge.
  task automatic press(input logic [3:0] k);
    @(negedge i_clk);
    i_key       = k;
    i_key_valid = 1'b1;
    @(negedge i_clk);
    i_key_valid = 1'b0;
  endtask

  task automatic press3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press(a);
    press(b);
    press(c);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
  endtask

  int e0;
  int l0;

  initial begin
    total       = 0;
    bad         = 0;
    i_rst_n     = 1'b0;
    i_en        = 1'b1;
    i_key_valid = 1'b0;
    i_key       = 4'h0;
    #3;
    check("rst_pw", 32'(o_password), 32'h0);
    check("rst_cnt", 32'(o_digit_cnt), 32'd0);
    check("rst_flags", {29'd0, o_unlock, o_error, o_locked}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Default code unlocks.
    e0 = err_seen;
    press3(4'd6, 4'd6, 4'd6);
    check("t1_pw", 32'(o_password), 32'h666);
    check("t1_cnt", 32'(o_digit_cnt), 32'd3);
    press(4'hB);
    check("t1_unlock", 32'(o_unlock), 32'd1);
    check("t1_pw_clr", 32'(o_password), 32'h0);
    check("t1_no_err", 32'(err_seen - e0), 32'd0);
    press(4'hA);
    check("t1_relock", 32'(o_unlock), 32'd0);

    // Fourth digit is ignored; wrong code rejected for one cycle.
    press3(4'd1, 4'd2, 4'd3);
    press(4'd4);
    check("t2_pw", 32'(o_password), 32'h123);
    check("t2_cnt", 32'(o_digit_cnt), 32'd3);
    press(4'hB);
    check("t2_err", 32'(o_error), 32'd1);
    check("t2_unlock", 32'(o_unlock), 32'd0);
    @(negedge i_clk);
    check("t2_err_1cyc", 32'(o_error), 32'd0);

    // Three mismatches -> lockout of 16 cycles.
    do_reset();
    e0 = err_seen;
    for (int n = 0; n < 3; n++) begin
      press3(4'd1, 4'd1, 4'd1);
      l0 = lock_seen;
      press(4'hB);
      check("t3_err", 32'(o_error), 32'd1);
    end
    check("t3_locked", 32'(o_locked), 32'd1);
    press(4'd5);
    press(4'd7);
    check("t3_pw_locked", 32'(o_password), 32'h0);
    check("t3_cnt_locked", 32'(o_digit_cnt), 32'd0);
    for (int i = 0; i < 40 && o_locked; i++) @(negedge i_clk);
    check("t3_unlocked_out", 32'(o_locked), 32'd0);
    check("t3_lock_len", 32'(lock_seen - l0), 32'd16);
    check("t3_err_cnt", 32'(err_seen - e0), 32'd3);
    press3(4'd6, 4'd6, 4'd6);
    press(4'hB);
    check("t3_reunlock", 32'(o_unlock), 32'd1);

    // Reprogram to 901.
    press(4'hC);
    check("t4_prog_unlock", 32'(o_unlock), 32'd0);
    press(4'hB);
    check("t4_short_err", 32'(o_error), 32'd1);
    press3(4'd9, 4'd0, 4'd1);
    check("t4_pw", 32'(o_password), 32'h901);
    press(4'hB);
    check("t4_stored", 32'(o_unlock), 32'd1);
    press(4'hA);
    check("t4_relock", 32'(o_unlock), 32'd0);
    press3(4'd6, 4'd6, 4'd6);
    press(4'hB);
    check("t4_old_err", 32'(o_error), 32'd1);
    press3(4'd9, 4'd0, 4'd1);
    press(4'hB);
    check("t4_new_unlock", 32'(o_unlock), 32'd1);
    press(4'hA);

    // Back-to-back strobes, D ignored, enable gating.
    @(negedge i_clk);
    i_key = 4'd4;
    i_key_valid = 1'b1;
    @(negedge i_clk);
    i_key = 4'd5;
    @(negedge i_clk);
    i_key_valid = 1'b0;
    check("t5_b2b_pw", 32'(o_password), 32'h045);
    press(4'hD);
    check("t5_codeD_cnt", 32'(o_digit_cnt), 32'd2);
    i_en = 1'b0;
    press(4'd7);
    i_en = 1'b1;
    check("t5_en_pw", 32'(o_password), 32'h045);
    check("t5_en_cnt", 32'(o_digit_cnt), 32'd2);

    // Async reset mid-entry, between edges.
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t5_arst_pw", 32'(o_password), 32'h0);
    check("t5_arst_cnt", 32'(o_digit_cnt), 32'd0);
    check("t5_arst_flags", {29'd0, o_unlock, o_error, o_locked}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    press3(4'd9, 4'd0, 4'd1);
    press(4'hB);
    check("t5_prog_lost", 32'(o_error), 32'd1);
    press3(4'd6, 4'd6, 4'd6);
    press(4'hB);
    check("t5_default_back", 32'(o_unlock), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
